// File: rtl/usb_sie_pkg.sv
// Shared definitions for the USB serial interface engine.
//   LINE_J / LINE_K / LINE_SE0 : 2-bit {dp,dm} line states
//   tx_line_state_t            : transmit line encoder FSM states
//   DEF_STUFF_LEN              : consecutive 1s that force a stuff bit
//   DEF_EOP_SE0_CYCLES         : SE0 length of an EOP in bit times
//   line_of()                  : map an NRZI data level to its line state
package usb_sie_pkg;

    localparam logic [1:0] LINE_J   = 2'b10;
    localparam logic [1:0] LINE_K   = 2'b01;
    localparam logic [1:0] LINE_SE0 = 2'b00;

    localparam int DEF_STUFF_LEN      = 6;
    localparam int DEF_EOP_SE0_CYCLES = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DATA,
        ST_STUFF,
        ST_EOP_SE0,
        ST_EOP_J
    } tx_line_state_t;

    // Data level 1 is J (idle), 0 is K.
    function automatic logic [1:0] line_of(input logic level);
        return level ? LINE_J : LINE_K;
    endfunction

endpackage

// File: rtl/usb_nrzi_bitstuff_tx.sv
// USB full-speed transmit line encoder: bit stuffing, NRZI encoding, EOP
// generation and line drive.
//   clk, rst       : bit-rate clock, asynchronous active-low reset
//   din/din_valid  : serial unencoded bit stream, LSB-first
//   din_last       : marks the final bit of a packet
//   din_ready      : bit accepted this cycle when din_valid is also high
//                    (decoded from state only)
//   dp/dm          : registered differential line levels
//   tx_en          : registered transceiver output enable
//   busy           : registered, high in any state except IDLE
//   underrun       : registered one-cycle pulse, source starved mid-packet
module usb_nrzi_bitstuff_tx
    import usb_sie_pkg::*;
#(
    parameter int STUFF_LEN      = DEF_STUFF_LEN,
    parameter int EOP_SE0_CYCLES = DEF_EOP_SE0_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    input  logic din_valid,
    input  logic din_last,
    output logic din_ready,
    output logic dp,
    output logic dm,
    output logic tx_en,
    output logic busy,
    output logic underrun
);

    localparam int OW = $clog2(STUFF_LEN + 1);
    localparam int SW = (EOP_SE0_CYCLES > 1) ? $clog2(EOP_SE0_CYCLES) : 1;

    tx_line_state_t state_q, state_d;
    logic           level_q, level_d;
    logic [OW-1:0]  ones_q, ones_d;
    logic [SW-1:0]  se0_cnt_q, se0_cnt_d;
    logic           last_pend_q, last_pend_d;
    logic [1:0]     line_q, line_d;
    logic           tx_en_q, tx_en_d;
    logic           busy_q, busy_d;
    logic           underrun_q, underrun_d;

    logic           accept;
    logic [OW-1:0]  ones_base;
    logic           bit_level;
    logic [OW-1:0]  bit_ones;
    logic           bit_stuff;

    assign din_ready = (state_q == ST_IDLE) || (state_q == ST_DATA);
    assign accept    = din_valid && din_ready;

    // Encoding of the presented bit, shared by IDLE and DATA. The ones
    // count restarts at zero for the first bit of a packet.
    always_comb begin
        ones_base = (state_q == ST_IDLE) ? '0 : ones_q;
        bit_level = din ? level_q : ~level_q;
        bit_ones  = din ? ones_base + OW'(1) : '0;
        bit_stuff = din && (ones_base == OW'(STUFF_LEN - 1));
    end

    always_comb begin
        state_d     = state_q;
        level_d     = level_q;
        ones_d      = ones_q;
        se0_cnt_d   = se0_cnt_q;
        last_pend_d = last_pend_q;
        line_d      = line_q;
        tx_en_d     = tx_en_q;
        underrun_d  = 1'b0;

        case (state_q)
            ST_IDLE, ST_DATA: begin
                if (accept) begin
                    level_d = bit_level;
                    line_d  = line_of(bit_level);
                    tx_en_d = 1'b1;
                    ones_d  = bit_ones;
                    if (bit_stuff) begin
                        // Stuff bit goes out before any EOP, so remember
                        // whether this bit closed the packet.
                        state_d     = ST_STUFF;
                        last_pend_d = din_last;
                    end else if (din_last) begin
                        state_d   = ST_EOP_SE0;
                        se0_cnt_d = SW'(EOP_SE0_CYCLES - 1);
                    end else begin
                        state_d = ST_DATA;
                    end
                end else if (state_q == ST_DATA) begin
                    // Source starved: truncate. This cycle already counts
                    // as the first SE0 bit time.
                    underrun_d = 1'b1;
                    line_d     = LINE_SE0;
                    tx_en_d    = 1'b1;
                    ones_d     = '0;
                    if (EOP_SE0_CYCLES > 1) begin
                        state_d   = ST_EOP_SE0;
                        se0_cnt_d = SW'(EOP_SE0_CYCLES - 2);
                    end else begin
                        state_d = ST_EOP_J;
                    end
                end else begin
                    line_d  = LINE_J;
                    tx_en_d = 1'b0;
                    level_d = 1'b1;
                    ones_d  = '0;
                end
            end

            ST_STUFF: begin
                level_d     = ~level_q;
                line_d      = line_of(~level_q);
                tx_en_d     = 1'b1;
                ones_d      = '0;
                last_pend_d = 1'b0;
                if (last_pend_q) begin
                    state_d   = ST_EOP_SE0;
                    se0_cnt_d = SW'(EOP_SE0_CYCLES - 1);
                end else begin
                    state_d = ST_DATA;
                end
            end

            ST_EOP_SE0: begin
                line_d  = LINE_SE0;
                tx_en_d = 1'b1;
                ones_d  = '0;
                if (se0_cnt_q == '0) begin
                    state_d = ST_EOP_J;
                end else begin
                    se0_cnt_d = se0_cnt_q - SW'(1);
                end
            end

            ST_EOP_J: begin
                line_d  = LINE_J;
                tx_en_d = 1'b1;
                level_d = 1'b1;
                ones_d  = '0;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
                level_d = 1'b1;
                ones_d  = '0;
                line_d  = LINE_J;
                tx_en_d = 1'b0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            level_q     <= 1'b1;
            ones_q      <= '0;
            se0_cnt_q   <= '0;
            last_pend_q <= 1'b0;
            line_q      <= LINE_J;
            tx_en_q     <= 1'b0;
            busy_q      <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            level_q     <= level_d;
            ones_q      <= ones_d;
            se0_cnt_q   <= se0_cnt_d;
            last_pend_q <= last_pend_d;
            line_q      <= line_d;
            tx_en_q     <= tx_en_d;
            busy_q      <= busy_d;
            underrun_q  <= underrun_d;
        end
    end

    assign dp       = line_q[1];
    assign dm       = line_q[0];
    assign tx_en    = tx_en_q;
    assign busy     = busy_q;
    assign underrun = underrun_q;

endmodule

// File: tb/tb_usb_nrzi_bitstuff_tx.sv
module tb_usb_nrzi_bitstuff_tx;

    logic clk = 1'b0;
    logic rst;
    logic din, din_valid, din_last;
    logic din_ready, dp, dm, tx_en, busy, underrun;

    int vecs = 0;
    int errs = 0;

    // Per-cycle traces of the most recent run(): one character per cycle.
    // line: J / K / 0 (SE0) / X seen after the edge closing that cycle.
    // rdy : din_ready during the cycle.
    string line_s, ten_s, rdy_s, und_s, bsy_s;
    int    acc_cnt;

    usb_nrzi_bitstuff_tx dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .din_last(din_last), .din_ready(din_ready), .dp(dp), .dm(dm),
        .tx_en(tx_en), .busy(busy), .underrun(underrun)
    );

    always #5 clk = ~clk;

    function automatic string lchar(input logic p, input logic m);
        case ({p, m})
            2'b10:   return "J";
            2'b01:   return "K";
            2'b00:   return "0";
            default: return "X";
        endcase
    endfunction

    function automatic string bchar(input logic b);
        return (b === 1'b1) ? "1" : "0";
    endfunction

    // Streams bits[0..nbits-1] LSB-first, holding each bit until accepted.
    // din_valid stays high until bit index drop_at (or the stream end).
    task automatic run(input logic [63:0] bits, input int nbits,
                       input logic [63:0] lastmask, input int drop_at,
                       input int ncyc);
        int  idx;
        logic acc;
        idx = 0; acc_cnt = 0;
        line_s = ""; ten_s = ""; rdy_s = ""; und_s = ""; bsy_s = "";
        for (int c = 0; c < ncyc; c++) begin
            din_valid = (idx < nbits) && (idx < drop_at);
            din       = bits[idx];
            din_last  = lastmask[idx];
            rdy_s     = {rdy_s, bchar(din_ready)};
            acc       = din_valid && din_ready;
            @(posedge clk); #1;
            if (acc) begin idx++; acc_cnt++; end
            line_s = {line_s, lchar(dp, dm)};
            ten_s  = {ten_s, bchar(tx_en)};
            und_s  = {und_s, bchar(underrun)};
            bsy_s  = {bsy_s, bchar(busy)};
        end
        din_valid = 1'b0; din = 1'b0; din_last = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0; din = 1'b0; din_valid = 1'b0; din_last = 1'b0;
        #12;
        vecs++; if ({dp, dm} !== 2'b10) begin errs++; $display("FAIL reset_line got %b want 10", {dp, dm}); end
        vecs++; if (tx_en !== 1'b0) begin errs++; $display("FAIL reset_tx_en got %b want 0", tx_en); end
        vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy got %b want 0", busy); end
        vecs++; if (underrun !== 1'b0) begin errs++; $display("FAIL reset_underrun got %b want 0", underrun); end
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        vecs++; if (din_ready !== 1'b1) begin errs++; $display("FAIL reset_ready got %b want 1", din_ready); end
        vecs++; if ({dp, dm, tx_en, busy} !== 4'b1000) begin errs++; $display("FAIL idle_after_reset got %b want 1000", {dp, dm, tx_en, busy}); end
    endtask

    task automatic test_sync;
        run(64'h80, 8, 64'h80, 8, 12);
        vecs++; if (line_s != "KJKJKJKK00JJ") begin errs++; $display("FAIL sync_line got %s want KJKJKJKK00JJ", line_s); end
        vecs++; if (ten_s != "111111111110") begin errs++; $display("FAIL sync_tx_en got %s want 111111111110", ten_s); end
        vecs++; if (rdy_s != "111111110001") begin errs++; $display("FAIL sync_ready got %s want 111111110001", rdy_s); end
        vecs++; if (bsy_s != "111111111100") begin errs++; $display("FAIL sync_busy got %s want 111111111100", bsy_s); end
        vecs++; if (und_s != "000000000000") begin errs++; $display("FAIL sync_underrun got %s want 000000000000", und_s); end
    endtask

    task automatic test_stuff_mid;
        // SYNC ends in a 1, so the 5th payload 1 is the 6th consecutive one.
        run(64'hFF80, 16, 64'h8000, 16, 21);
        vecs++; if (line_s != "KJKJKJKKKKKKKJJJJ00JJ") begin errs++; $display("FAIL stuff_line got %s want KJKJKJKKKKKKKJJJJ00JJ", line_s); end
        vecs++; if (ten_s != "111111111111111111110") begin errs++; $display("FAIL stuff_tx_en got %s want 111111111111111111110", ten_s); end
        vecs++; if (rdy_s != "111111111111101110001") begin errs++; $display("FAIL stuff_ready got %s want 111111111111101110001", rdy_s); end
        vecs++; if (acc_cnt != 16) begin errs++; $display("FAIL stuff_accepted got %0d want 16", acc_cnt); end
    endtask

    task automatic test_stuff_last;
        run(64'h3F, 6, 64'h20, 6, 11);
        vecs++; if (line_s != "JJJJJJK00JJ") begin errs++; $display("FAIL stuff_last_line got %s want JJJJJJK00JJ", line_s); end
        vecs++; if (ten_s != "11111111110") begin errs++; $display("FAIL stuff_last_tx_en got %s want 11111111110", ten_s); end
        vecs++; if (rdy_s != "11111100001") begin errs++; $display("FAIL stuff_last_ready got %s want 11111100001", rdy_s); end
    endtask

    task automatic test_underrun;
        run(64'h12, 8, 64'h0, 5, 9);
        vecs++; if (line_s != "KKJKK00JJ") begin errs++; $display("FAIL underrun_line got %s want KKJKK00JJ", line_s); end
        vecs++; if (und_s != "000001000") begin errs++; $display("FAIL underrun_pulse got %s want 000001000", und_s); end
        vecs++; if (ten_s != "111111110") begin errs++; $display("FAIL underrun_tx_en got %s want 111111110", ten_s); end
        vecs++; if (rdy_s != "111111001") begin errs++; $display("FAIL underrun_ready got %s want 111111001", rdy_s); end
        vecs++; if (acc_cnt != 5) begin errs++; $display("FAIL underrun_accepted got %0d want 5", acc_cnt); end
    endtask

    task automatic test_mid_reset;
        // Leaves the encoder at level K with five ones counted.
        run(64'h3E, 6, 64'h0, 6, 6);
        vecs++; if (line_s != "KKKKKK") begin errs++; $display("FAIL pre_reset_line got %s want KKKKKK", line_s); end
        #2 rst = 1'b0;
        #1;
        vecs++; if ({dp, dm, tx_en, busy, underrun} !== 5'b10000) begin errs++; $display("FAIL async_reset got %b want 10000", {dp, dm, tx_en, busy, underrun}); end
        vecs++; if (din_ready !== 1'b1) begin errs++; $display("FAIL async_reset_ready got %b want 1", din_ready); end
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        run(64'h3, 3, 64'h4, 3, 7);
        vecs++; if (line_s != "JJK00JJ") begin errs++; $display("FAIL post_reset_line got %s want JJK00JJ", line_s); end
        vecs++; if (rdy_s != "1110001") begin errs++; $display("FAIL post_reset_ready got %s want 1110001", rdy_s); end
    endtask

    task automatic test_back_to_back;
        // Packet A = 0,1 (ends at K); packet B = 1,0 with din_valid held.
        run(64'h6, 4, 64'hA, 4, 11);
        vecs++; if (line_s != "KK00JJK00JJ") begin errs++; $display("FAIL b2b_line got %s want KK00JJK00JJ", line_s); end
        vecs++; if (rdy_s != "11000110001") begin errs++; $display("FAIL b2b_ready got %s want 11000110001", rdy_s); end
        vecs++; if (ten_s != "11111111110") begin errs++; $display("FAIL b2b_tx_en got %s want 11111111110", ten_s); end
        vecs++; if (acc_cnt != 4) begin errs++; $display("FAIL b2b_accepted got %0d want 4", acc_cnt); end
    endtask

    initial begin
        test_reset;
        test_sync;
        test_stuff_mid;
        test_stuff_last;
        test_underrun;
        test_mid_reset;
        test_back_to_back;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running want finished");
        $fatal(1, "timeout");
    end

endmodule
